// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: FSM encoding,
// register-number width and default access timeout.
package mem_access_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int RN_W            = 5;
  localparam int DEFAULT_TIMEOUT = 255;

  // Word accesses only: both low address bits must be clear.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register: captures a completed instruction, otherwise
// inserts a bubble while keeping the last destination/data visible.
module mem_wb_reg
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              load_i,
  input  logic              wreg_i,
  input  logic [RN_W-1:0]   rn_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              wreg_o,
  output logic [RN_W-1:0]   rn_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic              wreg_q;
  logic [RN_W-1:0]   rn_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
      rn_q    <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      wreg_q  <= wreg_i;
      rn_q    <= rn_i;
      data_q  <= data_i;
    end else begin
      // Bubble: rn/data hold so a stalled view stays stable for debug.
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign wreg_o  = wreg_q;
  assign rn_o    = rn_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: runs the EXE/MEM instruction's data-memory access over
// a variable-latency req/ack port, stalls upstream until done, owns MEM/WB.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_Alu_Result,
  input  logic [DATA_W-1:0] mem_rb,
  input  logic              mem_wmem,
  input  logic              mem_m2reg,
  input  logic              mem_wreg,
  input  logic [RN_W-1:0]   mem_rn,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_wreg,
  output logic [RN_W-1:0]   wb_rn,
  output logic [DATA_W-1:0] wb_data,
  output logic              err_timeout,
  output logic              err_align
);

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_align_q, err_align_d;

  logic memop;
  logic misal;
  logic access;
  logic complete;
  logic abort;

  assign memop  = mem_valid & (mem_wmem | mem_m2reg);
  assign misal  = memop & ~is_word_aligned(mem_Alu_Result[1:0]);
  assign access = memop & ~misal;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
      err_align_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
      err_align_q   <= err_align_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b1;
    abort    = 1'b0;
    dm_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          dm_req = 1'b1;
          if (!dm_ack) begin
            complete = 1'b0;
            state_d  = ST_BUSY;
            cnt_d    = '0;
          end
        end
      end
      ST_BUSY: begin
        dm_req = 1'b1;
        if (dm_ack) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Ack wins over abort when both land in the final cycle.
          abort   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          complete = 1'b0;
          cnt_d    = cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    err_timeout_d = err_timeout_q | abort;
    err_align_d   = err_align_q | misal;
  end

  // Address/data come straight from EXE/MEM, which is frozen while stall is high.
  assign dm_we    = mem_wmem;
  assign dm_addr  = {mem_Alu_Result[DATA_W-1:2], 2'b00};
  assign dm_wdata = mem_rb;
  assign stall    = access & ~complete;

  logic              wb_load;
  logic              wb_wreg_in;
  logic [DATA_W-1:0] wb_data_in;

  assign wb_load    = complete & mem_valid;
  assign wb_wreg_in = mem_wreg & ~misal & ~abort;
  assign wb_data_in = mem_m2reg ? dm_rdata : mem_Alu_Result;

  mem_wb_reg #(
    .DATA_W (DATA_W)
  ) u_mem_wb_reg (
    .clk     (clk),
    .clrn    (clrn),
    .load_i  (wb_load),
    .wreg_i  (wb_wreg_in),
    .rn_i    (mem_rn),
    .data_i  (wb_data_in),
    .valid_o (wb_valid),
    .wreg_o  (wb_wreg),
    .rn_o    (wb_rn),
    .data_o  (wb_data)
  );

  assign err_timeout = err_timeout_q;
  assign err_align   = err_align_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized bench for mem_access_ctrl; expected behaviour is
// computed per instruction from its ack delay, not cycle-by-cycle state.
module tb_mem_access_ctrl;

  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          clrn = 1'b1;
  logic          mem_valid = 1'b0;
  logic [DW-1:0] mem_Alu_Result = '0;
  logic [DW-1:0] mem_rb = '0;
  logic          mem_wmem = 1'b0;
  logic          mem_m2reg = 1'b0;
  logic          mem_wreg = 1'b0;
  logic [4:0]    mem_rn = '0;
  logic          dm_req, dm_we;
  logic [DW-1:0] dm_addr, dm_wdata;
  logic          dm_ack = 1'b0;
  logic [DW-1:0] dm_rdata = '0;
  logic          stall, wb_valid, wb_wreg;
  logic [4:0]    wb_rn;
  logic [DW-1:0] wb_data;
  logic          err_timeout, err_align;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_W(DW), .TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .clrn(clrn), .mem_valid(mem_valid), .mem_Alu_Result(mem_Alu_Result),
    .mem_rb(mem_rb), .mem_wmem(mem_wmem), .mem_m2reg(mem_m2reg), .mem_wreg(mem_wreg),
    .mem_rn(mem_rn), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_data(wb_data),
    .err_timeout(err_timeout), .err_align(err_align)
  );

  int checks = 0;
  int failures = 0;

  logic          exp_valid, exp_wreg, exp_eto, exp_eal;
  logic [4:0]    exp_rn;
  logic [DW-1:0] exp_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_valid = 1'b0; exp_wreg = 1'b0; exp_rn = '0; exp_data = '0;
    exp_eto = 1'b0; exp_eal = 1'b0;
  endtask

  task automatic check_wb(input string tag);
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(exp_valid));
    chk({tag, ".wb_wreg"}, 32'(wb_wreg), 32'(exp_wreg));
    chk({tag, ".wb_rn"}, 32'(wb_rn), 32'(exp_rn));
    chk({tag, ".wb_data"}, wb_data, exp_data);
    chk({tag, ".err_timeout"}, 32'(err_timeout), 32'(exp_eto));
    chk({tag, ".err_align"}, 32'(err_align), 32'(exp_eal));
  endtask

  // One instruction held in EXE/MEM until it completes. d = cycle (0 = entry
  // cycle) on which memory acks; d > TO means memory never answers.
  task automatic run_instr(input string tag, input bit v, input bit w, input bit m,
                           input bit wr, input logic [4:0] rn, input logic [31:0] alu,
                           input logic [31:0] rb, input bit fix_rd,
                           input logic [31:0] rd_fixed, input int d);
    bit memop, misal, acc, aborted;
    int done;
    logic [31:0] rd;
    memop   = v && (w || m);
    misal   = memop && (alu[1:0] != 2'b00);
    acc     = memop && !misal;
    aborted = acc && (d > TO);
    done    = !acc ? 0 : (d <= TO ? d : TO);
    rd      = '0;
    for (int k = 0; k <= done; k++) begin
      @(negedge clk);
      if (k == 0) begin
        mem_valid = v; mem_wmem = w; mem_m2reg = m; mem_wreg = wr;
        mem_rn = rn; mem_Alu_Result = alu; mem_rb = rb;
      end
      rd = fix_rd ? rd_fixed : $urandom;
      dm_rdata = rd;
      dm_ack = acc && (k == d);
      #1;
      chk({tag, ".stall"}, 32'(stall), 32'(k < done));
      chk({tag, ".dm_req"}, 32'(dm_req), 32'(acc));
      if (acc && k == 0) begin
        chk({tag, ".dm_we"}, 32'(dm_we), 32'(w));
        chk({tag, ".dm_addr"}, dm_addr, {alu[31:2], 2'b00});
        chk({tag, ".dm_wdata"}, dm_wdata, rb);
      end
    end
    @(posedge clk);
    #1;
    dm_ack = 1'b0;
    if (v) begin
      exp_valid = 1'b1;
      exp_wreg  = wr && !misal && !aborted;
      exp_rn    = rn;
      exp_data  = m ? rd : alu;
    end else begin
      exp_valid = 1'b0;
      exp_wreg  = 1'b0;
    end
    if (misal) exp_eal = 1'b1;
    if (aborted) exp_eto = 1'b1;
    check_wb(tag);
  endtask

  initial begin
    model_reset();
    #1 clrn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset.dm_req", 32'(dm_req), 32'd0);
    chk("reset.stall", 32'(stall), 32'd0);
    check_wb("reset");
    clrn = 1'b1;

    run_instr("alu", 1, 0, 0, 1, 5'd5, 32'h10, 32'h0, 0, 32'h0, 0);
    run_instr("load_ack2", 1, 0, 1, 1, 5'd7, 32'h100, 32'h0, 1, 32'hDEADBEEF, 2);
    run_instr("store_ack0", 1, 1, 0, 0, 5'd0, 32'h20, 32'h55, 0, 32'h0, 0);
    run_instr("load_misal", 1, 0, 1, 1, 5'd9, 32'h102, 32'h0, 0, 32'h0, 0);
    run_instr("load_timeout", 1, 0, 1, 1, 5'd3, 32'h200, 32'h0, 0, 32'h0, 99);
    run_instr("alu_after_to", 1, 0, 0, 1, 5'd12, 32'hCAFE0001, 32'h0, 0, 32'h0, 0);
    run_instr("ack_at_last", 1, 0, 1, 1, 5'd4, 32'h300, 32'h0, 1, 32'h12345678, TO);
    run_instr("bubble", 0, 1, 1, 1, 5'd6, 32'h400, 32'h0, 0, 32'h0, 0);
    run_instr("ld_st_both", 1, 1, 1, 1, 5'd8, 32'h44, 32'h77, 1, 32'hA5A5A5A5, 1);

    // Reset in the middle of an access; upstream EXE/MEM resets to a bubble too.
    @(negedge clk);
    mem_valid = 1; mem_wmem = 0; mem_m2reg = 1; mem_wreg = 1;
    mem_rn = 5'd10; mem_Alu_Result = 32'h40; dm_ack = 0;
    @(negedge clk);
    #1;
    chk("midrst.stall_busy", 32'(stall), 32'd1);
    @(negedge clk);
    clrn = 1'b0;
    mem_valid = 1'b0;
    #1;
    model_reset();
    chk("midrst.dm_req", 32'(dm_req), 32'd0);
    chk("midrst.stall", 32'(stall), 32'd0);
    check_wb("midrst");
    @(negedge clk);
    clrn = 1'b1;
    run_instr("load_after_rst", 1, 0, 1, 1, 5'd11, 32'h80, 32'h0, 1, 32'h0BADF00D, 1);

    for (int i = 0; i < 150; i++) begin
      bit v, w, m, wr;
      logic [31:0] alu;
      v   = ($urandom_range(0, 7) != 0);
      w   = $urandom_range(0, 1);
      m   = $urandom_range(0, 1);
      wr  = $urandom_range(0, 1);
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      run_instr("rand", v, w, m, wr, 5'($urandom), alu, $urandom, 0, 32'h0,
                int'($urandom_range(0, TO + 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
